// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam int DW_DEF = 8;

  // One-hot grant encodings: bit N set means requester N owns the write port
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S0   = 2'b01;
  localparam logic [1:0] GRANT_S1   = 2'b10;

endpackage

// File: rtl/fifo_out_reg.sv
// One-entry holding stage in front of the FIFO write port; advertises ld when it can take a byte.
module fifo_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_vld,
  input  logic [DW-1:0] din_data,
  input  logic          wr_full,
  output logic          ld,
  output logic          wr_req,
  output logic [DW-1:0] wr_data
);

  logic          out_vld;
  logic [DW-1:0] out_data;

  assign wr_req  = out_vld & ~wr_full;
  assign wr_data = out_data;
  // Space exists when empty, or when the held byte leaves this cycle
  assign ld      = ~out_vld | wr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (ld && din_vld) begin
      out_vld  <= 1'b1;
      out_data <= din_data;
    end else if (wr_req) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-aware round-robin arbiter sharing one FIFO write port between two byte requesters.
// Handshake: a beat transfers on sN_valid & sN_ready; ready never depends on the same port's valid.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  input  logic [DW-1:0]    s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [DW-1:0]    s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  input  logic             wr_full,
  output logic             wr_req,
  output logic [DW-1:0]    wr_data,
  output logic [1:0]       grant,
  output logic             burst_cut,
  output state_t           dbg_state,
  output logic             dbg_last_win,
  output logic [CNT_W-1:0] dbg_cnt
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nx;
  logic             last_win, last_win_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             burst_cut_nx;

  logic             ld;
  logic             acc0, acc1, acc;
  logic             beat_last;
  logic             at_limit;
  logic [DW-1:0]    din_data;

  fifo_out_reg #(.DW(DW)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .din_vld  (acc),
    .din_data (din_data),
    .wr_full  (wr_full),
    .ld       (ld),
    .wr_req   (wr_req),
    .wr_data  (wr_data)
  );

  assign s0_ready  = ld & (state == G0);
  assign s1_ready  = ld & (state == G1);
  assign acc0      = s0_valid & s0_ready;
  assign acc1      = s1_valid & s1_ready;
  assign acc       = acc0 | acc1;
  assign din_data  = acc0 ? s0_data : s1_data;
  assign beat_last = acc0 ? s0_last : s1_last;
  assign at_limit  = (cnt == CNT_LIM);

  always_comb begin
    state_nx     = state;
    last_win_nx  = last_win;
    cnt_nx       = cnt;
    burst_cut_nx = 1'b0;
    case (state)
      IDLE: begin
        // On contention the port that did not win last time goes first
        if (s0_valid && (!s1_valid || last_win)) begin
          state_nx    = G0;
          last_win_nx = 1'b0;
          cnt_nx      = '0;
        end else if (s1_valid) begin
          state_nx    = G1;
          last_win_nx = 1'b1;
          cnt_nx      = '0;
        end
      end
      G0, G1: begin
        if (acc) begin
          if (beat_last || at_limit) begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            burst_cut_nx = ~beat_last;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_win  <= 1'b1;
      cnt       <= '0;
      burst_cut <= 1'b0;
    end else begin
      state     <= state_nx;
      last_win  <= last_win_nx;
      cnt       <= cnt_nx;
      burst_cut <= burst_cut_nx;
    end
  end

  always_comb begin
    case (state)
      G0:      grant = GRANT_S0;
      G1:      grant = GRANT_S1;
      default: grant = GRANT_NONE;
    endcase
  end

  assign dbg_state    = state;
  assign dbg_last_win = last_win;
  assign dbg_cnt      = cnt;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed test-plan scenarios plus randomized traffic, all checked
// against a transaction-level arbitration model and a one-entry expected-write queue.
module tb_fifo_wr_arb;
  import fifo_arb_pkg::*;

  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] gap;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s0_valid = 1'b0, s1_valid = 1'b0;
  logic [DW-1:0]    s0_data = '0, s1_data = '0;
  logic             s0_last = 1'b0, s1_last = 1'b0;
  logic             s0_ready, s1_ready;
  logic             wr_full = 1'b0;
  logic             wr_req;
  logic [DW-1:0]    wr_data;
  logic [1:0]       grant;
  logic             burst_cut;
  state_t           dbg_state;
  logic             dbg_last_win;
  logic [CNT_W-1:0] dbg_cnt;

  fifo_wr_arb #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .wr_full(wr_full), .wr_req(wr_req), .wr_data(wr_data),
    .grant(grant), .burst_cut(burst_cut),
    .dbg_state(dbg_state), .dbg_last_win(dbg_last_win), .dbg_cnt(dbg_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver, scoreboard and model state
  beat_t         src_q[2][$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] want[$];
  int            errors = 0, checks = 0;
  bit            vld[2], armed[2], hs[2];
  int            wait_c[2], pct[2], acc_cnt[2];
  int            cut_cnt = 0;
  bit            rand_full = 0;
  int            full_pct = 0;
  int            m_owner = -1, m_beats = 0, m_prev = 1;
  logic [DW-1:0] m_last_out = '0;
  bit            m_cut = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle: compare outputs to the model, then advance the model across the coming edge
  task automatic monitor();
    bit         space, ex_wreq, v, l;
    logic [7:0] d;
    space   = (exp_q.size() == 0) || !wr_full;
    ex_wreq = (exp_q.size() != 0) && !wr_full;
    check("grant", grant, (m_owner == 0) ? GRANT_S0 : (m_owner == 1) ? GRANT_S1 : GRANT_NONE);
    check("s0_ready", s0_ready, (m_owner == 0) && space);
    check("s1_ready", s1_ready, (m_owner == 1) && space);
    check("wr_req", wr_req, ex_wreq);
    check("wr_data", wr_data, m_last_out);
    check("burst_cut", burst_cut, m_cut);
    check("last_win", dbg_last_win, m_prev);
    check("idle_state", dbg_state == IDLE, m_owner < 0);
    if (m_owner >= 0) check("cnt", dbg_cnt, m_beats);
    if (wr_req) wr_log.push_back(wr_data);
    if (burst_cut) cut_cnt++;
    hs[0] = s0_valid && s0_ready;
    hs[1] = s1_valid && s1_ready;
    if (hs[0]) acc_cnt[0]++;
    if (hs[1]) acc_cnt[1]++;
    if (rst) begin
      exp_q.delete();
      m_owner = -1; m_beats = 0; m_prev = 1; m_last_out = '0; m_cut = 0;
    end else begin
      m_cut = 0;
      if (ex_wreq) void'(exp_q.pop_front());
      if (m_owner < 0) begin
        if (s0_valid && s1_valid) m_owner = 1 - m_prev;
        else if (s0_valid)        m_owner = 0;
        else if (s1_valid)        m_owner = 1;
        if (m_owner >= 0) begin
          m_prev  = m_owner;
          m_beats = 0;
        end
      end else begin
        v = (m_owner == 0) ? s0_valid : s1_valid;
        l = (m_owner == 0) ? s0_last  : s1_last;
        d = (m_owner == 0) ? s0_data  : s1_data;
        if (v && space) begin
          exp_q.push_back(d);
          m_last_out = d;
          m_beats++;
          if (l || m_beats == MAX_BURST) begin
            m_cut   = !l;
            m_owner = -1;
          end
        end
      end
    end
  endtask

  task automatic drive_all();
    for (int p = 0; p < 2; p++) begin
      if (hs[p] && src_q[p].size() > 0) begin
        void'(src_q[p].pop_front());
        armed[p] = 0;
        vld[p]   = 0;
      end
      hs[p] = 0;
      if (src_q[p].size() == 0) vld[p] = 0;
      else if (!vld[p]) begin
        if (!armed[p]) begin
          armed[p]  = 1;
          wait_c[p] = int'(src_q[p][0].gap);
        end
        if (wait_c[p] > 0) wait_c[p]--;
        else if ($urandom_range(99) < pct[p]) vld[p] = 1;
      end
    end
    s0_valid = vld[0];
    s0_data  = vld[0] ? src_q[0][0].data : '0;
    s0_last  = vld[0] ? src_q[0][0].last : 1'b0;
    s1_valid = vld[1];
    s1_data  = vld[1] ? src_q[1][0].data : '0;
    s1_last  = vld[1] ? src_q[1][0].last : 1'b0;
    if (rand_full) wr_full = ($urandom_range(99) < full_pct);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive_all();
  endtask

  task automatic push_beat(input int p, input logic [7:0] d, input bit l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = 4'(gap);
    src_q[p].push_back(b);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, GRANT_NONE);
    check({tag, "_wr_req"}, wr_req, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_s0_ready"}, s0_ready, 0);
    check({tag, "_s1_ready"}, s1_ready, 0);
    check({tag, "_burst_cut"}, burst_cut, 0);
    check({tag, "_cnt"}, dbg_cnt, 0);
    check({tag, "_last_win"}, dbg_last_win, 1);
    check({tag, "_state_idle"}, dbg_state == IDLE, 1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      src_q[p].delete();
      vld[p] = 0; armed[p] = 0; hs[p] = 0;
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    tick();
    rst = 1'b0;
    check_reset_vals(tag);
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((src_q[0].size() != 0 || src_q[1].size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", n < budget, 1);
    repeat (3) tick();
  endtask

  task automatic check_log(input string tag);
    int n;
    check({tag, "_len"}, wr_log.size(), want.size());
    n = (wr_log.size() < want.size()) ? wr_log.size() : want.size();
    for (int i = 0; i < n; i++) check(tag, wr_log[i], want[i]);
    wr_log.delete();
  endtask

  initial begin
    int acc_base, n, total;
    pct = '{100, 100};
    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // single packet
    wr_log.delete();
    push_beat(0, 8'hA1, 0, 0);
    push_beat(0, 8'hA2, 0, 0);
    push_beat(0, 8'hA3, 1, 0);
    run_drain(50);
    want = '{8'hA1, 8'hA2, 8'hA3};
    check_log("single");

    // contention from reset
    do_reset("rst_c");
    wr_log.delete();
    push_beat(0, 8'h10, 0, 0);
    push_beat(0, 8'h11, 1, 0);
    push_beat(1, 8'h20, 1, 0);
    run_drain(50);
    want = '{8'h10, 8'h11, 8'h20};
    check_log("contention");
    check("contention_last_win", dbg_last_win, 1);

    // backpressure mid-packet
    for (int i = 0; i < 4; i++) push_beat(0, 8'(8'h70 + i), i == 3, 0);
    repeat (3) tick();
    wr_full  = 1'b1;
    acc_base = acc_cnt[0];
    repeat (5) tick();
    check("bp_absorb", (acc_cnt[0] - acc_base) <= 1, 1);
    wr_full = 1'b0;
    run_drain(50);
    want = '{8'h70, 8'h71, 8'h72, 8'h73};
    check_log("backpressure");

    // burst limit: s1 streams without last, s0 arrives during the burst
    do_reset("rst_b");
    wr_log.delete();
    cut_cnt = 0;
    for (int i = 0; i < 6; i++) push_beat(1, 8'(8'h30 + i), 0, 0);
    push_beat(0, 8'h40, 1, 2);
    run_drain(100);
    want = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h34, 8'h35};
    check_log("burst");
    check("burst_cut_count", cut_cnt, 1);

    // reset mid-burst with a byte held
    do_reset("rst_m0");
    wr_log.delete();
    acc_base = acc_cnt[0];
    for (int i = 0; i < 4; i++) push_beat(0, 8'(8'h80 + i), i == 3, 0);
    n = 0;
    while (acc_cnt[0] < acc_base + 2 && n < 50) begin
      tick();
      n++;
    end
    check("rst_mid_timeout", n < 50, 1);
    wr_full = 1'b1;
    do_reset("rst_m1");
    wr_full = 1'b0;
    repeat (3) tick();
    want = '{8'h80};
    check_log("rst_mid");
    push_beat(0, 8'h90, 1, 0);
    push_beat(1, 8'h91, 1, 0);
    run_drain(50);
    want = '{8'h90, 8'h91};
    check_log("rst_contention");

    // stall inside a grant while the other port waits
    push_beat(0, 8'h50, 0, 0);
    push_beat(0, 8'h51, 0, 3);
    push_beat(0, 8'h52, 0, 0);
    push_beat(0, 8'h53, 1, 0);
    push_beat(1, 8'h60, 1, 1);
    run_drain(60);
    want = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
    check_log("stall");

    // randomized traffic with random backpressure
    wr_log.delete();
    total = 0;
    pct[0] = $urandom_range(100, 30);
    pct[1] = $urandom_range(100, 30);
    rand_full = 1;
    full_pct  = 30;
    for (int k = 0; k < 20; k++) begin
      for (int p = 0; p < 2; p++) begin
        int len = $urandom_range(7, 1);
        for (int i = 0; i < len; i++)
          push_beat(p, 8'($urandom_range(255)), i == len - 1, $urandom_range(2));
        total += len;
      end
    end
    run_drain(4000);
    rand_full = 0;
    wr_full   = 1'b0;
    repeat (3) tick();
    check("rand_count", wr_log.size(), total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Two-requester, packet-aware round-robin arbiter that shares the single write port of the byte FIFO between two byte sources, for example the UART receive path and a test-pattern source. It runs in the FIFO write clock domain. It presents valid/ready handshakes to the requesters and drives the FIFO `wr_req`/`wr_data` pair, honouring `wr_full`. A grant is held until the requester's packet ends or a burst limit is reached, so bytes of one packet stay contiguous in the FIFO.

## Interface
- `DW`, 8: byte/data width.
- `MAX_BURST`, 16: maximum accepted beats per grant; must be ≥1.
- `CNT_W`, `$clog2(MAX_BURST+1)`: burst counter width (derived).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high. One clock; reset is synchronous and active-high.
- `s0_valid`  in  1  requester 0 has a byte.
- `s0_data`  in  DW  requester 0 byte.
- `s0_last`  in  1  byte is the final byte of the packet.
- `s0_ready`  out  1  beat accepted when `s0_valid & s0_ready`.
- `s1_valid`, `s1_data`, `s1_last`, `s1_ready`: same as port 0, for requester 1.
- `wr_full`  in  1  FIFO full flag.
- `wr_req`  out  1  FIFO write strobe.
- `wr_data`  out  DW  FIFO write byte.
- `grant`  out  2  one-hot current owner; `00` in IDLE.
- `burst_cut`  out  1  one-cycle pulse when a grant ends on `MAX_BURST` rather than on last.

## Operation
- One-entry output holding register, with `out_vld` and `out_data`.
  - `wr_req = out_vld & ~wr_full` (combinational).
  - `wr_data = out_data`.
- Load enable: `ld = ~out_vld | wr_req`.
- `sN_ready = ld & (state == GN)`, combinational. Both ready signals are never high together.
- An accepted beat loads `out_data` and sets `out_vld`. Without a new beat, `wr_req` clears `out_vld`.
- Round-robin pointer `last_win` records the port granted most recently. Its reset value is 1, so port 0 wins the first contention.
- State machine:
  - **IDLE**:
    - If exactly one `sN_valid` is high, go to GN.
    - If both are high, go to the port that is not `last_win`.
    - On entry to GN, set `last_win = N` and clear `cnt`.
  - **GN**:
    - Each accepted beat increments `cnt`.
    - An accepted beat with `sN_last`, or with `cnt == MAX_BURST-1`, goes to IDLE.
    - The second case also pulses `burst_cut`, only when `sN_last` is 0.
- While in GN, `sN_valid` low does not release the grant. The arbiter waits, and the other port is blocked. Requesters must complete packets.
- After `burst_cut` the packet is resumed on a later grant. Interleaving with the other port at that boundary is allowed.
- No byte is ever dropped or duplicated while `rst` is low.

## Timing
- Reset values (cycle after `rst` high):
  - `state` = IDLE.
  - `out_vld` = 0, `out_data` = 0.
  - `wr_req` = 0, `wr_data` = 0.
  - `s0_ready` = `s1_ready` = 0.
  - `grant` = 00, `burst_cut` = 0, `cnt` = 0, `last_win` = 1.
- Reset mid-burst discards the held byte and the grant. It has priority over all other updates.
- Arbitration latency is one cycle: IDLE with a valid request at edge t gives GN from t+1, when `sN_ready` can rise.
- Data latency: a beat accepted at edge t appears on `wr_data` with `wr_req` high in cycle t+1 if `wr_full` is 0.
- Throughput is one byte per cycle inside a grant. There is a one-cycle bubble per grant (the GN→IDLE→GM transition).
- When `wr_full` is high: `wr_req` is 0, `out_data` is held, and `ld = ~out_vld`. At most one beat is absorbed, then `sN_ready` drops.
- `burst_cut` is registered and high exactly one cycle, the cycle after the terminating beat.
- `cnt` never exceeds `MAX_BURST-1`. `MAX_BURST = 1` gives a single-beat grant.

## Structure
- Package `fifo_arb_pkg`:
  - state enum {IDLE, G0, G1};
  - default `DW`;
  - one-hot grant constants.
- Sub-module `fifo_out_reg`: the one-entry holding stage. Its ports are `ld`, the din pair, `wr_full`, `wr_req` and `wr_data`.
- The top module holds the state machine, counter and round-robin pointer.

## Test plan
- **Single packet.** Stimulus: `s0` sends 0xA1, 0xA2, 0xA3 (last on 0xA3), `wr_full` = 0. Required response:
  - `grant` = 01 one cycle after `s0_valid`;
  - `wr_req` high for 3 consecutive cycles with A1, A2, A3;
  - `grant` back to 00.
- **Contention from reset.** Stimulus: `s0` packet 0x10, 0x11 (last) and `s1` packet 0x20 (last), both valid at once. Required response:
  - FIFO write order is 10, 11, 20;
  - `last_win` ends at 1.
- **Backpressure.** Stimulus: `wr_full` high for 5 cycles mid-packet. Required response:
  - `wr_req` = 0 and `wr_data` held;
  - `s0_ready` low after at most one extra beat;
  - full sequence written exactly once after release.
- **Burst limit.** Stimulus: `MAX_BURST` = 4; `s1` streams 0x30–0x35 with no last; `s0` valid with 0x40 (last). Required response:
  - writes 30–33;
  - `burst_cut` pulses once;
  - then 40;
  - then 34, 35.
- **Reset mid-burst.** Stimulus: `rst` high for 1 cycle after 2 of 4 beats. Required response:
  - all outputs at reset values the next cycle;
  - held byte not written;
  - `s0` wins the next contention.
- **Stall inside grant.** Stimulus: `s0_valid` drops for 3 cycles mid-packet while `s1_valid` is high. Required response:
  - `grant` stays 01;
  - `s1_ready` stays 0;
  - `s0` packet completes before any `s1` byte.
